// File: rtl/key_mux_reg.sv
// Keyed lookup mux (OR of all entries whose key matches) feeding a load-enabled register.
// Optional KEY_MUX_DEFAULT_EN adds a default_out input that is used when no key matches.
module key_mux_reg #(
    parameter int                  NR_KEY    = 2,
    parameter int                  KEY_LEN   = 1,
    parameter int                  DATA_LEN  = 32,
    parameter logic [DATA_LEN-1:0] RESET_VAL = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [KEY_LEN-1:0]                   key,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
    input  logic                                 wen,
`ifdef KEY_MUX_DEFAULT_EN
    input  logic [DATA_LEN-1:0]                  default_out,
`endif
    output logic [DATA_LEN-1:0]                  mux_out,
    output logic [DATA_LEN-1:0]                  dout
);

    localparam int PAIR = KEY_LEN + DATA_LEN;

    logic [DATA_LEN-1:0] hit_data;
    logic                any_hit;
    logic [DATA_LEN-1:0] dout_d;
    logic [DATA_LEN-1:0] dout_q;

    // Only matching entries contribute, so X in unused entries cannot leak out.
    always_comb begin
        hit_data = '0;
        any_hit  = 1'b0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (lut[PAIR*i+DATA_LEN +: KEY_LEN] == key) begin
                hit_data = hit_data | lut[PAIR*i +: DATA_LEN];
                any_hit  = 1'b1;
            end
        end
    end

    always_comb begin
`ifdef KEY_MUX_DEFAULT_EN
        mux_out = any_hit ? hit_data : default_out;
`else
        mux_out = any_hit ? hit_data : '0;
`endif
    end

    always_comb begin
        dout_d = dout_q;
        if (wen) begin
            dout_d = mux_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= RESET_VAL;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_key_mux_reg.sv
// Scoreboard bench for key_mux_reg: three instances (fetch-style table, 2-bit keys with a
// missing key, duplicate keys). Expectations are queued with the cycle they fall due.
module tb_key_mux_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        key, wen, wen2, wen3, key3;
    logic [1:0]  key2;
    logic [31:0] mux_out, dout, mux_out2, dout2, mux_out3, dout3;
    logic [31:0] default_out = 32'hDEAD_BEEF;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

`ifdef KEY_MUX_DEFAULT_EN
    localparam logic [31:0] NOMATCH = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] NOMATCH = 32'h0000_0000;
`endif

    logic [65:0] lut1 = {1'b1, 32'h8000_0100, 1'b0, 32'h8000_0004};
    logic [67:0] lut2 = {2'b10, 32'h3333_3333, 2'b01, 32'h2222_2222};
    logic [65:0] lut3 = {1'b0, 32'h0000_00F0, 1'b0, 32'h0000_000F};

    key_mux_reg #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32), .RESET_VAL(32'h8000_0000)) dut (
        .clk(clk), .rst(rst), .key(key), .lut(lut1), .wen(wen),
`ifdef KEY_MUX_DEFAULT_EN
        .default_out(default_out),
`endif
        .mux_out(mux_out), .dout(dout));

    key_mux_reg #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(32), .RESET_VAL(32'h0)) dut2 (
        .clk(clk), .rst(rst), .key(key2), .lut(lut2), .wen(wen2),
`ifdef KEY_MUX_DEFAULT_EN
        .default_out(default_out),
`endif
        .mux_out(mux_out2), .dout(dout2));

    key_mux_reg #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32), .RESET_VAL(32'h5A5A_5A5A)) dut3 (
        .clk(clk), .rst(rst), .key(key3), .lut(lut3), .wen(wen3),
`ifdef KEY_MUX_DEFAULT_EN
        .default_out(default_out),
`endif
        .mux_out(mux_out3), .dout(dout3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    task automatic expect_at(input int due, input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.due  = due;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return mux_out;
            1:       return dout;
            2:       return mux_out2;
            3:       return dout2;
            4:       return mux_out3;
            default: return dout3;
        endcase
    endfunction

    // Monitor: mid-cycle, compare every expectation due this cycle; overdue ones are errors.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                logic [31:0] got;
                got = observe(sb[i].sel);
                checks++;
                if (sb[i].due < cyc) begin
                    errors++;
                    $display("FAIL %s: overdue at cycle %0d (due %0d)", sb[i].name, cyc, sb[i].due);
                end else if (got !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s: cycle %0d got %h expected %h", sb[i].name, cyc, got, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wen = 1'b1; key = 1'b1;
        key2 = 2'b11; wen2 = 1'b1;
        key3 = 1'b0; wen3 = 1'b1;
        step();                                   // cyc 1: reset edge taken
        expect_at(cyc, 1, 32'h8000_0000, "rst_dout");
        expect_at(cyc, 3, 32'h0000_0000, "rst_dout2");
        expect_at(cyc, 5, 32'h5A5A_5A5A, "rst_dout3");
        expect_at(cyc, 2, NOMATCH,       "nomatch_mux2");
        expect_at(cyc, 4, 32'h0000_00FF, "dupkey_mux3");

        rst = 1'b0; key = 1'b0;
        expect_at(cyc,     0, 32'h8000_0004, "mux_key0");
        expect_at(cyc,     1, 32'h8000_0000, "dout_before_load");
        expect_at(cyc + 1, 1, 32'h8000_0004, "dout_key0");
        expect_at(cyc + 1, 3, NOMATCH,       "nomatch_dout2");
        expect_at(cyc + 1, 5, 32'h0000_00FF, "dupkey_dout3");
        step();                                   // cyc 2

        key = 1'b1; key2 = 2'b01; key3 = 1'b1;
        expect_at(cyc,     0, 32'h8000_0100, "mux_key1");
        expect_at(cyc + 1, 1, 32'h8000_0100, "dout_key1");
        expect_at(cyc,     2, 32'h2222_2222, "mux2_key01");
        expect_at(cyc + 1, 3, 32'h2222_2222, "dout2_key01");
        expect_at(cyc,     4, NOMATCH,       "nomatch_mux3");
        expect_at(cyc + 1, 5, NOMATCH,       "nomatch_dout3");
        step();                                   // cyc 3

        wen = 1'b0; key = 1'b0; wen2 = 1'b0; key2 = 2'b10; wen3 = 1'b0; key3 = 1'b0;
        expect_at(cyc, 0, 32'h8000_0004, "mux_follows_wen0");
        for (int k = 0; k < 4; k++)
            expect_at(cyc + k, 1, 32'h8000_0100, "dout_hold");
        expect_at(cyc,     2, 32'h3333_3333, "mux2_key10");
        expect_at(cyc + 1, 3, 32'h2222_2222, "dout2_hold");
        expect_at(cyc,     4, 32'h0000_00FF, "mux3_key0");
        expect_at(cyc + 1, 5, NOMATCH,       "dout3_hold");
        step(); step(); step();                   // cyc 6

        rst = 1'b1; wen = 1'b1; key = 1'b0; wen2 = 1'b1; wen3 = 1'b1;
        expect_at(cyc,     0, 32'h8000_0004, "mux_during_rst");
        expect_at(cyc + 1, 1, 32'h8000_0000, "rst_beats_wen");
        expect_at(cyc + 1, 3, 32'h0000_0000, "rst_beats_wen2");
        expect_at(cyc + 1, 5, 32'h5A5A_5A5A, "rst_beats_wen3");
        step();                                   // cyc 7

        rst = 1'b0; wen = 1'b0; key = 1'b1; wen2 = 1'b0; wen3 = 1'b0;
        expect_at(cyc,     0, 32'h8000_0100, "mux_after_rst");
        expect_at(cyc + 1, 1, 32'h8000_0000, "dout_hold_after_rst");
        step();
        step();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
